// File: rtl/wb_lsu_master.sv
`default_nettype none
// ============================================================================
// Module      : wb_lsu_master
// Description : Wishbone B4 classic initiator for the RV32I load/store path.
//               Accepts one request at a time, checks alignment, steers byte
//               lanes, runs a single Wishbone cycle and returns extended load
//               data or an error. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_lsu_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  // request side
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  // response side
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [31:0]           rsp_rdata,
  // Wishbone
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [3:0]            wb_sel_o,
  output logic [31:0]           wb_dat_o,
  input  logic [31:0]           wb_dat_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] c_to_last =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [1:0] c_sz_byte = 2'b00;
  localparam logic [1:0] c_sz_half = 2'b01;
  localparam logic [1:0] c_sz_word = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state, w_state_n;
  logic [1:0]            r_size,  w_size_n;
  logic                  r_uns,   w_uns_n;
  logic [1:0]            r_a,     w_a_n;
  logic [CNT_W-1:0]      r_cnt,   w_cnt_n;
  logic                  r_ready, w_ready_n;
  logic                  r_cyc,   w_cyc_n;
  logic                  r_we,    w_we_n;
  logic [ADDR_WIDTH-1:0] r_adr,   w_adr_n;
  logic [3:0]            r_sel,   w_sel_n;
  logic [31:0]           r_dat,   w_dat_n;
  logic                  r_rv,    w_rv_n;
  logic                  r_rerr,  w_rerr_n;
  logic [31:0]           r_rdata, w_rdata_n;

  logic                  w_bad;
  logic [31:0]           w_rsh;
  logic [31:0]           w_ext;
  logic                  w_timeout;

  // Alignment / size legality of the incoming request.
  always_comb begin
    w_bad = 1'b0;
    case (req_size)
      c_sz_half: w_bad = req_addr[0];
      c_sz_word: w_bad = |req_addr[1:0];
      c_sz_byte: w_bad = 1'b0;
      default:   w_bad = 1'b1;
    endcase
  end

  // Right-align the read lane and sign/zero-extend it per the latched size.
  always_comb begin
    w_rsh = wb_dat_i >> {r_a, 3'b000};
    w_ext = w_rsh;
    case (r_size)
      c_sz_byte: w_ext = r_uns ? {24'h0, w_rsh[7:0]}  : {{24{w_rsh[7]}},  w_rsh[7:0]};
      c_sz_half: w_ext = r_uns ? {16'h0, w_rsh[15:0]} : {{16{w_rsh[15]}}, w_rsh[15:0]};
      default:   w_ext = w_rsh;
    endcase
  end

  assign w_timeout = (TIMEOUT_CYCLES > 0) && (r_cnt == c_to_last);

  // Next-state and next-output logic; outputs are registered below.
  always_comb begin
    w_state_n = r_state;
    w_size_n  = r_size;
    w_uns_n   = r_uns;
    w_a_n     = r_a;
    w_cnt_n   = r_cnt;
    w_ready_n = r_ready;
    w_cyc_n   = r_cyc;
    w_we_n    = r_we;
    w_adr_n   = r_adr;
    w_sel_n   = r_sel;
    w_dat_n   = r_dat;
    w_rv_n    = 1'b0;
    w_rerr_n  = 1'b0;
    w_rdata_n = 32'h0;
    case (r_state)
      S_IDLE: begin
        w_ready_n = 1'b1;
        w_cnt_n   = '0;
        if (req_valid) begin
          w_size_n  = req_size;
          w_uns_n   = req_unsigned;
          w_a_n     = req_addr[1:0];
          w_ready_n = 1'b0;
          if (w_bad) begin
            // Rejected without touching the bus.
            w_state_n = S_RESP;
            w_rv_n    = 1'b1;
            w_rerr_n  = 1'b1;
          end else begin
            w_state_n = S_BUS;
            w_cyc_n   = 1'b1;
            w_we_n    = req_we;
            w_adr_n   = {req_addr[ADDR_WIDTH-1:2], 2'b00};
            case (req_size)
              c_sz_byte: begin
                w_sel_n = 4'b0001 << req_addr[1:0];
                w_dat_n = {24'h0, req_wdata[7:0]} << {req_addr[1:0], 3'b000};
              end
              c_sz_half: begin
                w_sel_n = 4'b0011 << req_addr[1:0];
                w_dat_n = {16'h0, req_wdata[15:0]} << {req_addr[1:0], 3'b000};
              end
              default: begin
                w_sel_n = 4'b1111;
                w_dat_n = req_wdata;
              end
            endcase
          end
        end
      end
      S_BUS: begin
        w_cnt_n = r_cnt + 1'b1;
        if (wb_err_i || wb_ack_i || w_timeout) begin
          // Single STB phase: drop the bus on the edge that enters RESP.
          w_state_n = S_RESP;
          w_rv_n    = 1'b1;
          w_cyc_n   = 1'b0;
          w_we_n    = 1'b0;
          w_adr_n   = '0;
          w_sel_n   = 4'h0;
          w_dat_n   = 32'h0;
          if (wb_err_i || !wb_ack_i) begin
            w_rerr_n = 1'b1;
          end else if (!r_we) begin
            w_rdata_n = w_ext;
          end
        end
      end
      S_RESP: begin
        w_state_n = S_IDLE;
        w_ready_n = 1'b1;
        w_cnt_n   = '0;
      end
      default: begin
        w_state_n = S_IDLE;
        w_ready_n = 1'b1;
        w_cyc_n   = 1'b0;
      end
    endcase
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
      r_a     <= 2'b00;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_cyc   <= 1'b0;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_sel   <= 4'h0;
      r_dat   <= 32'h0;
      r_rv    <= 1'b0;
      r_rerr  <= 1'b0;
      r_rdata <= 32'h0;
    end else begin
      r_state <= w_state_n;
      r_size  <= w_size_n;
      r_uns   <= w_uns_n;
      r_a     <= w_a_n;
      r_cnt   <= w_cnt_n;
      r_ready <= w_ready_n;
      r_cyc   <= w_cyc_n;
      r_we    <= w_we_n;
      r_adr   <= w_adr_n;
      r_sel   <= w_sel_n;
      r_dat   <= w_dat_n;
      r_rv    <= w_rv_n;
      r_rerr  <= w_rerr_n;
      r_rdata <= w_rdata_n;
    end
  end

  assign req_ready = r_ready;
  assign rsp_valid = r_rv;
  assign rsp_err   = r_rerr;
  assign rsp_rdata = r_rdata;
  assign wb_cyc_o  = r_cyc;
  assign wb_stb_o  = r_cyc;
  assign wb_we_o   = r_we;
  assign wb_adr_o  = r_adr;
  assign wb_sel_o  = r_sel;
  assign wb_dat_o  = r_dat;

endmodule
`default_nettype wire

// File: tb/tb_wb_lsu_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_lsu_master
// Description : Directed-vector bench for wb_lsu_master. The stimulus process
//               queues the expected response of each request; a monitor pops
//               and compares whenever the DUT pulses rsp_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_lsu_master;

  localparam int AW = 32;
  localparam int TO = 16;

  // responder modes
  localparam int M_ACK  = 0;
  localparam int M_ERR  = 1;
  localparam int M_BOTH = 2;
  localparam int M_NONE = 3;
  localparam int M_REJ  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_we, req_unsigned;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          req_ready, rsp_valid, rsp_err;
  logic [31:0]   rsp_rdata;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW-1:0] wb_adr_o;
  logic [3:0]    wb_sel_o;
  logic [31:0]   wb_dat_o, wb_dat_i;
  logic          wb_ack_i, wb_err_i;

  wb_lsu_master #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt++;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cycle;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Response monitor: every rsp_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 at cycle %0d, expected none", cyc_cnt);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, "_err"},   {31'h0, rsp_err}, {31'h0, e.err});
        chk({e.name, "_rdata"}, rsp_rdata,        e.rdata);
        chk({e.name, "_cycle"}, cyc_cnt,          e.cycle);
      end
    end
  end

  // One request with a scripted responder; bus-phase outputs checked inline.
  task automatic do_req(input string name, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] e_adr, input logic [3:0] e_sel,
                        input logic [31:0] e_dat, input int mode, input int waits,
                        input logic [31:0] dat_i, input logic e_err,
                        input logic [31:0] e_rdata);
    exp_t e;
    int   lat;
    @(negedge clk);
    chk({name, "_ready"}, {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    case (mode)
      M_REJ:  lat = 1;
      M_NONE: lat = TO + 1;
      default: lat = waits + 2;
    endcase
    e.err = e_err; e.rdata = e_rdata; e.cycle = cyc_cnt + lat; e.name = name;
    exp_q.push_back(e);
    @(negedge clk);  // cycle 1
    req_valid = 1'b0; req_wdata = 32'h0;
    if (mode == M_REJ) begin
      chk({name, "_nocyc"}, {31'h0, wb_cyc_o}, 32'h0);
    end else begin
      chk({name, "_cycstb"}, {30'h0, wb_cyc_o, wb_stb_o}, 32'h3);
      chk({name, "_we"},  {31'h0, wb_we_o}, {31'h0, we});
      chk({name, "_adr"}, wb_adr_o, e_adr);
      chk({name, "_sel"}, {28'h0, wb_sel_o}, {28'h0, e_sel});
      chk({name, "_dat"}, wb_dat_o, e_dat);
      if (mode == M_NONE) begin
        for (int i = 2; i <= TO; i++) begin
          @(negedge clk);
          chk({name, "_held"}, {31'h0, wb_cyc_o}, 32'h1);
        end
      end else begin
        for (int i = 0; i < waits; i++) begin
          @(negedge clk);
          chk({name, "_wait"}, {31'h0, wb_cyc_o}, 32'h1);
        end
        wb_dat_i = dat_i;
        wb_ack_i = (mode == M_ACK) || (mode == M_BOTH);
        wb_err_i = (mode == M_ERR) || (mode == M_BOTH);
      end
      @(negedge clk);  // response cycle
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = 32'h5A5A5A5A;
      chk({name, "_drop"}, {31'h0, wb_cyc_o}, 32'h0);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    wb_dat_i = 32'h5A5A5A5A; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_outs", {28'h0, rsp_valid, rsp_err, wb_cyc_o, wb_stb_o}, 32'h0);
    chk("rst_bus", wb_adr_o | wb_dat_o | {28'h0, wb_sel_o} | {31'h0, wb_we_o}, 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // ack/err outside BUS must not produce a response
    wb_ack_i = 1'b1; wb_err_i = 1'b1;
    @(negedge clk);
    wb_ack_i = 1'b0; wb_err_i = 1'b0;
    @(negedge clk);

    //      name    we  size   uns addr        wdata         e_adr       e_sel    e_dat         mode    w  dat_i         err   rdata
    do_req("SW",    1, 2'b10, 0, 32'h40010, 32'hDEADBEEF, 32'h40010, 4'b1111, 32'hDEADBEEF, M_ACK,  0, 32'h11111111, 1'b0, 32'h0);
    do_req("SB",    1, 2'b00, 0, 32'h13,    32'h000000A5, 32'h10,    4'b1000, 32'hA5000000, M_ACK,  0, 32'h0,        1'b0, 32'h0);
    do_req("SH",    1, 2'b01, 0, 32'h2,     32'h1234BEEF, 32'h0,     4'b1100, 32'hBEEF0000, M_ACK,  1, 32'h0,        1'b0, 32'h0);
    do_req("LB",    0, 2'b00, 0, 32'h22,    32'h0,        32'h20,    4'b0100, 32'h0,        M_ACK,  3, 32'h0080FF00, 1'b0, 32'hFFFFFF80);
    do_req("LBU",   0, 2'b00, 1, 32'h22,    32'h0,        32'h20,    4'b0100, 32'h0,        M_ACK,  3, 32'h0080FF00, 1'b0, 32'h00000080);
    do_req("LH",    0, 2'b01, 0, 32'h2,     32'h0,        32'h0,     4'b1100, 32'h0,        M_ACK,  0, 32'h80011234, 1'b0, 32'hFFFF8001);
    do_req("LHU",   0, 2'b01, 1, 32'h2,     32'h0,        32'h0,     4'b1100, 32'h0,        M_ACK,  0, 32'h80011234, 1'b0, 32'h00008001);
    do_req("LW",    0, 2'b10, 1, 32'h8,     32'h0,        32'h8,     4'b1111, 32'h0,        M_ACK,  1, 32'h87654321, 1'b0, 32'h87654321);
    do_req("LWmis", 0, 2'b10, 0, 32'h6,     32'h0,        32'h0,     4'b0000, 32'h0,        M_REJ,  0, 32'h0,        1'b1, 32'h0);
    do_req("LHmis", 0, 2'b01, 0, 32'h3,     32'h0,        32'h0,     4'b0000, 32'h0,        M_REJ,  0, 32'h0,        1'b1, 32'h0);
    do_req("SZ11",  1, 2'b11, 0, 32'h0,     32'h0,        32'h0,     4'b0000, 32'h0,        M_REJ,  0, 32'h0,        1'b1, 32'h0);
    do_req("BERR",  1, 2'b10, 0, 32'hC,     32'hCAFEBABE, 32'hC,     4'b1111, 32'hCAFEBABE, M_ERR,  2, 32'h0,        1'b1, 32'h0);
    do_req("BOTH",  0, 2'b10, 0, 32'h104,   32'h0,        32'h104,   4'b1111, 32'h0,        M_BOTH, 0, 32'hFFFFFFFF, 1'b1, 32'h0);
    do_req("TMO",   0, 2'b10, 0, 32'h100,   32'h0,        32'h100,   4'b1111, 32'h0,        M_NONE, 0, 32'h0,        1'b1, 32'h0);

    // reset during a waiting LW: bus drops, no response, ready returns
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h30;
    @(negedge clk);  // cycle 1
    req_valid = 1'b0;
    chk("RST_cyc1", {31'h0, wb_cyc_o}, 32'h1);
    @(negedge clk);  // cycle 2
    rst = 1'b1;
    @(negedge clk);  // cycle 3
    rst = 1'b0;
    chk("RST_drop", {30'h0, wb_cyc_o, wb_stb_o}, 32'h0);
    chk("RST_ready", {31'h0, req_ready}, 32'h1);
    repeat (2) @(negedge clk);
    do_req("AFTER", 0, 2'b10, 0, 32'h20, 32'h0, 32'h20, 4'b1111, 32'h0, M_ACK, 0, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D);

    // drain: every expected response must have been seen
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain", exp_q.size(), 32'h0);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
